// File: rtl/theta_mix.sv
// theta_mix: Keccak theta step applied lane by lane to a streamed 25-lane state,
// using column parities supplied on start.
module theta_mix #(
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [5*W-1:0] c_in,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_lane,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_lane,
  output logic [4:0]     out_idx,
  output logic           finish
);
  typedef enum logic [1:0] {IDLE, PREP, STREAM, DONE} state_t;
  state_t         state;
  logic [5*W-1:0] c_q;
  logic [W-1:0]   d [5];
  logic [4:0]     cnt;
  logic [2:0]     col;
  logic           xfer;
  logic           drain;
  assign in_ready = state == STREAM && cnt <= 5'd24 && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      c_q       <= '0;
      for (int x = 0; x < 5; x++) d[x] <= '0;
      cnt       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_lane  <= '0;
      out_idx   <= '0;
      finish    <= 1'b0;
    end else begin
      finish <= 1'b0;
      if (drain) out_valid <= 1'b0;
      if (xfer) begin
        out_valid <= 1'b1;
        out_lane  <= in_lane ^ d[col];
        out_idx   <= cnt;
        cnt       <= cnt + 5'd1;
        col       <= col == 3'd4 ? 3'd0 : col + 3'd1;
      end
      case (state)
        IDLE: if (start) begin
          c_q   <= c_in;
          state <= PREP;
        end
        PREP: begin
          for (int x = 0; x < 5; x++)
            d[x] <= c_q[((x+4)%5)*W +: W] ^ {c_q[((x+1)%5)*W +: W-1], c_q[((x+1)%5)*W + W-1]};
          cnt   <= '0;
          col   <= '0;
          state <= STREAM;
        end
        STREAM: if (drain && out_idx == 5'd24) begin
          state  <= DONE;
          finish <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_theta_mix.sv
// tb_theta_mix: randomized self-checking bench for theta_mix against a lane-level theta model.
module tb_theta_mix;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [319:0] c_in;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_lane;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_lane;
  logic [4:0]   out_idx;
  logic         finish;
  int total = 0;
  int bad = 0;
  logic [63:0] lanes [25];
  logic [63:0] got_lane [25];
  int          got_idx [25];
  int          n_out;
  int          n_fin;
  bit          timed_out;

  theta_mix #(.W(64)) dut (
    .clk(clk), .rst(rst), .start(start), .c_in(c_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_lane(in_lane),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane(out_lane),
    .out_idx(out_idx), .finish(finish)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] exp_lane(input logic [319:0] c, input int i, input logic [63:0] a);
    int x;
    logic [63:0] cm, cp;
    x  = i % 5;
    cm = c[((x+4)%5)*64 +: 64];
    cp = c[((x+1)%5)*64 +: 64];
    return a ^ cm ^ ((cp << 1) | (cp >> 63));
  endfunction

  function automatic logic [319:0] rand_c();
    logic [319:0] r;
    for (int k = 0; k < 10; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic rand_lanes();
    for (int i = 0; i < 25; i++) lanes[i] = {$urandom, $urandom};
  endtask

  task automatic run_block(input logic [319:0] c, input bit rand_hs, input bit hold_start);
    int nxt;
    int cyc;
    int post;
    nxt = 0; cyc = 0; post = 0;
    n_out = 0; n_fin = 0; timed_out = 0;
    @(negedge clk);
    start = 1'b1; c_in = c; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    while (post < 4) begin
      c_in      = rand_c();
      in_valid  = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rand_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_lane   = lanes[nxt % 25];
      #1;
      if (in_valid && in_ready) nxt++;
      if (out_valid && out_ready) begin
        if (n_out < 25) begin
          got_lane[n_out] = out_lane;
          got_idx[n_out]  = int'(out_idx);
        end
        n_out++;
      end
      if (finish) begin
        n_fin++;
        start = 1'b0;
      end
      if (n_fin > 0) post++;
      @(negedge clk);
      cyc++;
      if (cyc >= 2000) begin
        timed_out = 1;
        post = 4;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; c_in = '0; in_valid = 1'b0; out_ready = 1'b0; in_lane = '0;
    #3;
    total++;
    if ({out_valid, finish, in_ready} !== 3'b000 || out_lane !== 64'h0 || out_idx !== 5'd0) begin
      bad++;
      $display("FAIL reset_async: out_valid=%b finish=%b in_ready=%b lane=%h idx=%0d, need all 0", out_valid, finish, in_ready, out_lane, out_idx);
    end
    @(posedge clk); #1;
    total++;
    if ({out_valid, finish, in_ready} !== 3'b000 || out_lane !== 64'h0 || out_idx !== 5'd0) begin
      bad++;
      $display("FAIL reset_held: out_valid=%b finish=%b in_ready=%b lane=%h idx=%0d, need all 0", out_valid, finish, in_ready, out_lane, out_idx);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 25; i++) lanes[i] = 64'(i + 1);
    run_block('0, 0, 0);
    total++;
    if (timed_out || n_out !== 25 || n_fin !== 1) begin
      bad++;
      $display("FAIL passthrough_count: outs=%0d fins=%0d timeout=%0b, need 25/1/0", n_out, n_fin, timed_out);
    end
    for (int i = 0; i < 25 && i < n_out; i++) begin
      total++;
      if (got_idx[i] !== i || got_lane[i] !== 64'(i + 1)) begin
        bad++;
        $display("FAIL passthrough lane %0d: got %h idx %0d, need %h idx %0d", i, got_lane[i], got_idx[i], 64'(i + 1), i);
      end
    end
  endtask

  task automatic test_vectors();
    logic [319:0] c;
    logic [63:0] want;
    for (int i = 0; i < 25; i++) lanes[i] = '0;
    c = '0;
    c[1*64 +: 64] = 64'h1;
    run_block(c, 0, 0);
    total++;
    if (timed_out || n_out !== 25 || n_fin !== 1) begin
      bad++;
      $display("FAIL vec1_count: outs=%0d fins=%0d, need 25/1", n_out, n_fin);
    end
    for (int i = 0; i < 25 && i < n_out; i++) begin
      want = (i % 5 == 0) ? 64'h2 : (i % 5 == 2) ? 64'h1 : 64'h0;
      total++;
      if (got_idx[i] !== i || got_lane[i] !== want) begin
        bad++;
        $display("FAIL vec1 lane %0d: got %h idx %0d, need %h", i, got_lane[i], got_idx[i], want);
      end
    end
    c = '0;
    c[1*64 +: 64] = 64'h8000_0000_0000_0000;
    c[4*64 +: 64] = 64'h5;
    run_block(c, 0, 0);
    total++;
    if (timed_out || n_out !== 25 || n_fin !== 1) begin
      bad++;
      $display("FAIL vec2_count: outs=%0d fins=%0d, need 25/1", n_out, n_fin);
    end
    for (int i = 0; i < 25 && i < n_out; i++) begin
      want = (i % 5 == 0) ? 64'h4 : (i % 5 == 3) ? 64'hA :
             (i % 5 == 2) ? 64'h8000_0000_0000_0000 : 64'h0;
      total++;
      if (got_idx[i] !== i || got_lane[i] !== want) begin
        bad++;
        $display("FAIL vec2 lane %0d: got %h idx %0d, need %h", i, got_lane[i], got_idx[i], want);
      end
    end
  endtask

  task automatic test_random();
    logic [319:0] c;
    for (int b = 0; b < 4; b++) begin
      c = rand_c();
      rand_lanes();
      run_block(c, 1, 0);
      total++;
      if (timed_out || n_out !== 25 || n_fin !== 1) begin
        bad++;
        $display("FAIL random%0d_count: outs=%0d fins=%0d timeout=%0b, need 25/1/0", b, n_out, n_fin, timed_out);
      end
      for (int i = 0; i < 25 && i < n_out; i++) begin
        total++;
        if (got_idx[i] !== i || got_lane[i] !== exp_lane(c, i, lanes[i])) begin
          bad++;
          $display("FAIL random%0d lane %0d: got %h idx %0d, need %h", b, i, got_lane[i], got_idx[i], exp_lane(c, i, lanes[i]));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [319:0] c;
    int nxt;
    int cyc;
    bit stalled;
    bit fin;
    c = rand_c();
    rand_lanes();
    nxt = 0; cyc = 0; stalled = 0; fin = 0;
    @(negedge clk);
    start = 1'b1; c_in = c; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 300) begin
      c_in = rand_c();
      if (!stalled && out_valid && out_idx == 5'd7) begin
        stalled = 1;
        for (int k = 0; k < 3; k++) begin
          out_ready = 1'b0; in_valid = 1'b1; in_lane = lanes[nxt % 25];
          #1;
          total++;
          if (out_valid !== 1'b1 || out_idx !== 5'd7 || out_lane !== exp_lane(c, 7, lanes[7]) || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall cycle %0d: valid=%b idx=%0d lane=%h in_ready=%b, need 1/7/%h/0", k, out_valid, out_idx, out_lane, in_ready, exp_lane(c, 7, lanes[7]));
          end
          @(negedge clk);
        end
        out_ready = 1'b1; in_valid = 1'b1; in_lane = lanes[nxt % 25];
        #1;
        if (in_valid && in_ready) nxt++;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_idx !== 5'd8 || out_lane !== exp_lane(c, 8, lanes[8])) begin
          bad++;
          $display("FAIL stall_release: valid=%b idx=%0d lane=%h, need 1/8/%h", out_valid, out_idx, out_lane, exp_lane(c, 8, lanes[8]));
        end
      end else begin
        out_ready = 1'b1; in_valid = 1'b1; in_lane = lanes[nxt % 25];
        #1;
        if (in_valid && in_ready) nxt++;
        if (finish) fin = 1;
        @(negedge clk);
      end
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (!stalled || !fin) begin
      bad++;
      $display("FAIL stall_block: stalled=%0b finished=%0b, need 1/1", stalled, fin);
    end
  endtask

  task automatic test_abort();
    logic [319:0] c;
    int nxt;
    int cyc;
    int spurious;
    c = rand_c();
    rand_lanes();
    nxt = 0; cyc = 0; spurious = 0;
    @(negedge clk);
    start = 1'b1; c_in = c; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!(out_valid && out_idx == 5'd12) && cyc < 200) begin
      in_valid = 1'b1; in_lane = lanes[nxt % 25];
      #1;
      if (in_valid && in_ready) nxt++;
      if (finish) spurious++;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (out_valid !== 1'b1 || out_idx !== 5'd12) begin
      bad++;
      $display("FAIL abort_reach12: valid=%b idx=%0d, need 1/12", out_valid, out_idx);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({out_valid, finish, in_ready} !== 3'b000 || out_lane !== 64'h0 || out_idx !== 5'd0) begin
      bad++;
      $display("FAIL abort_clear: valid=%b finish=%b in_ready=%b lane=%h idx=%0d, need all 0", out_valid, finish, in_ready, out_lane, out_idx);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; out_ready = 1'b1; in_lane = lanes[(12 + k) % 25];
      #1;
      if (out_valid || finish || in_ready) spurious++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++;
    if (spurious !== 0) begin
      bad++;
      $display("FAIL abort_quiet: %0d cycles with output/finish/ready activity, need 0", spurious);
    end
    for (int i = 0; i < 25; i++) lanes[i] = {$urandom, $urandom};
    run_block('0, 0, 0);
    total++;
    if (timed_out || n_out !== 25 || n_fin !== 1) begin
      bad++;
      $display("FAIL abort_restart_count: outs=%0d fins=%0d, need 25/1", n_out, n_fin);
    end
    for (int i = 0; i < 25 && i < n_out; i++) begin
      total++;
      if (got_idx[i] !== i || got_lane[i] !== lanes[i]) begin
        bad++;
        $display("FAIL abort_restart lane %0d: got %h idx %0d, need %h", i, got_lane[i], got_idx[i], lanes[i]);
      end
    end
  endtask

  task automatic test_start_held();
    logic [319:0] c;
    int spurious;
    spurious = 0;
    c = rand_c();
    rand_lanes();
    run_block(c, 1, 1);
    total++;
    if (timed_out || n_out !== 25 || n_fin !== 1) begin
      bad++;
      $display("FAIL held_count: outs=%0d fins=%0d, need 25/1", n_out, n_fin);
    end
    for (int i = 0; i < 25 && i < n_out; i++) begin
      total++;
      if (got_idx[i] !== i || got_lane[i] !== exp_lane(c, i, lanes[i])) begin
        bad++;
        $display("FAIL held lane %0d: got %h idx %0d, need %h", i, got_lane[i], got_idx[i], exp_lane(c, i, lanes[i]));
      end
    end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      if (out_valid || finish || in_ready) spurious++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++;
    if (spurious !== 0) begin
      bad++;
      $display("FAIL held_extra_block: %0d active cycles after block, need 0", spurious);
    end
    c = rand_c();
    rand_lanes();
    run_block(c, 0, 0);
    total++;
    if (timed_out || n_out !== 25 || n_fin !== 1) begin
      bad++;
      $display("FAIL held_next_count: outs=%0d fins=%0d, need 25/1", n_out, n_fin);
    end
    for (int i = 0; i < 25 && i < n_out; i++) begin
      total++;
      if (got_idx[i] !== i || got_lane[i] !== exp_lane(c, i, lanes[i])) begin
        bad++;
        $display("FAIL held_next lane %0d: got %h idx %0d, need %h", i, got_lane[i], got_idx[i], exp_lane(c, i, lanes[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_vectors();
    test_random();
    test_backpressure();
    test_abort();
    test_start_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
